// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin arbiter/sequencer sharing one combinational
// alu_8bit core between up to eight requesters. One operation is in flight
// at a time: IDLE (grant) -> EXEC (ALU driven from latched operands) ->
// RESP (result held until rsp_ready).
// Optional build macro: ALU_ARB_PRIO_EN gives requester 0 strict priority
// without moving the round-robin pointer. Undefined = pure round-robin.
module alu_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [8*NREQ-1:0]   req_a,
  input  logic [8*NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0]   req_op,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [2:0]          alu_op,
  input  logic [7:0]          alu_result,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2:0]          rsp_id,
  output logic [7:0]          rsp_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]          state_r;
  logic [2:0]          ptr_r;
  logic [7:0]          a_r;
  logic [7:0]          b_r;
  logic [2:0]          op_r;
  logic [2:0]          id_r;
  logic [7:0]          res_r;

  logic [2*NREQ-1:0]   rot_s;
  logic                found_s;
  logic [2:0]          off_s;
  logic [3:0]          sum_s;
  logic [2:0]          win_s;
  logic                prio_hit_s;
  logic [2:0]          ptr_nxt_s;
  logic [7:0]          sel_a_s;
  logic [7:0]          sel_b_s;
  logic [2:0]          sel_op_s;

  // Find the first valid requester at or above ptr (wrapping), or requester 0 under priority
  always_comb begin
    found_s = 1'b0;
    off_s   = 3'd0;
    sum_s   = 4'd0;
    win_s   = 3'd0;
`ifdef ALU_ARB_PRIO_EN
    prio_hit_s = req_valid[0];
`else
    prio_hit_s = 1'b0;
`endif
    // Doubling the vector turns the wrapping scan into a straight scan from bit 0
    rot_s = {req_valid, req_valid} >> ptr_r;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        off_s   = 3'(k);
      end else begin
        found_s = found_s;
        off_s   = off_s;
      end
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    if (prio_hit_s) begin
      win_s = 3'd0;
    end else if (sum_s >= 4'(NREQ)) begin
      win_s = 3'(sum_s - 4'(NREQ));
    end else begin
      win_s = sum_s[2:0];
    end
  end

  // Pointer value after a round-robin grant: one past the winner, modulo NREQ
  always_comb begin
    if (win_s == 3'(NREQ - 1)) begin
      ptr_nxt_s = 3'd0;
    end else begin
      ptr_nxt_s = win_s + 3'd1;
    end
  end

  // Steer the winner's operands and opcode onto the latch inputs (AND-OR mux)
  always_comb begin
    sel_a_s  = 8'd0;
    sel_b_s  = 8'd0;
    sel_op_s = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a_s  = sel_a_s  | (req_a[8*i +: 8]  & {8{win_s == 3'(i)}});
      sel_b_s  = sel_b_s  | (req_b[8*i +: 8]  & {8{win_s == 3'(i)}});
      sel_op_s = sel_op_s | (req_op[3*i +: 3] & {3{win_s == 3'(i)}});
    end
  end

  // One-hot grant, only offered while idle
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = (state_r == ST_IDLE) && (found_s || prio_hit_s) && (win_s == 3'(i));
    end
  end

  // Sequencer: latch on grant, capture ALU result in EXEC, hold response until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= 3'd0;
      a_r     <= 8'd0;
      b_r     <= 8'd0;
      op_r    <= 3'd0;
      id_r    <= 3'd0;
      res_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s || prio_hit_s) begin
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            op_r    <= sel_op_s;
            id_r    <= win_s;
            // A priority win of requester 0 leaves the rotation untouched
            ptr_r   <= prio_hit_s ? ptr_r : ptr_nxt_s;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_r   <= alu_result;
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = a_r;
  assign alu_b      = b_r;
  assign alu_op     = op_r;
  assign rsp_valid  = (state_r == ST_RESP);
  assign rsp_id     = id_r;
  assign rsp_result = res_r;

endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational `alu_8bit` core between up to eight requesters. Each requester presents an operation with a valid/ready handshake. The block grants one requester, drives the shared ALU from registered operands, and captures the result. It then returns the result with the requester's ID on a single valid/ready response channel. It sits between the requesting engines and the ALU core and replaces direct per-engine ALU instances.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; legal range 2..8.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  request i is pending.
- `req_ready`  out  NREQ  one-hot grant; request i is accepted when both `req_valid[i]` and `req_ready[i]` are high.
- `req_a`  in  8*NREQ  operand A; slice [8i+7:8i] belongs to requester i.
- `req_b`  in  8*NREQ  operand B, same packing.
- `req_op`  in  3*NREQ  opcode, packed 3 bits per requester; same encoding as `alu_8bit`.
- `alu_a`, `alu_b`  out  8  operands to the shared ALU.
- `alu_op`  out  3  opcode to the shared ALU.
- `alu_result`  in  8  combinational result from the shared ALU.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  3  index of the requester that owns the response.
- `rsp_result`  out  8  captured ALU result.

## Operation
The FSM has three states: IDLE, EXEC and RESP.

IDLE:
- `req_ready` is a combinational one-hot vector over the valid requests.
- The winner is the first valid index found scanning from `ptr` upward, wrapping modulo NREQ.
- If no request is valid, `req_ready` is 0 and the FSM stays in IDLE.
- On a grant, the block latches `req_a`, `req_b` and `req_op` of the winner, plus its ID, then sets `ptr` to (winner+1) mod NREQ and moves to EXEC.

EXEC:
- `alu_a`, `alu_b` and `alu_op` are driven from the latched registers.
- `alu_result` is captured into `rsp_result`.
- The FSM moves to RESP.

RESP:
- `rsp_valid` is 1; `rsp_id` and `rsp_result` hold steady.
- On `rsp_valid & rsp_ready` the FSM returns to IDLE.
- Without `rsp_ready` the FSM stays in RESP indefinitely.

General rules:
- `req_ready` is 0 in EXEC and RESP. At most one request is in flight.
- `alu_*` outputs hold their last latched values outside EXEC. They are 0 after reset.
- The block performs no arithmetic; results are exactly the 8-bit truncated `alu_8bit` values.
- A requester dropping `req_valid` in IDLE before it is granted is legal; it is simply not granted.
- Requester inputs must be stable while `req_valid` is high until acceptance.

## Timing
- Reset values: state IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `alu_a`=`alu_b`=0, `alu_op`=0.
- Latency: acceptance in cycle N, EXEC in N+1, `rsp_valid` high in N+2.
- Minimum issue interval is 3 cycles. This holds when `rsp_ready` is already high in RESP; the next grant can then occur in cycle N+3.
- Simultaneous requests: exactly one is granted per IDLE cycle. The losers keep `req_valid` high and are served in rotation.
- Fairness: each continuously asserted requester is granted within NREQ grants.
- `rst` asserted in any state, including mid-EXEC or mid-RESP, returns to reset values on the next edge. The in-flight operation is discarded and no response is produced.

## Configuration
- `ALU_ARB_PRIO_EN` defined:
  - Requester 0 has strict priority. If `req_valid[0]` is high in IDLE it wins regardless of `ptr`, and `ptr` is left unchanged.
  - All other requesters use round-robin as above.
- `ALU_ARB_PRIO_EN` undefined: pure round-robin for all requesters. This is the default build.

## Test plan
1. Reset then single request: requester 2 sends a=8'd200, b=8'd100, op=000. Required: accepted in cycle 0, `rsp_valid` high in cycle 2 with `rsp_id`=2 and `rsp_result`=8'd44; the ALU is driven with 200/100/000 during cycle 1.
2. All four requesters valid continuously after reset. Required: grant order 0,1,2,3,0. Also run with op=010, a=16, b=16 and check `rsp_result`=0 (truncated multiply).
3. Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP. Required: `rsp_valid`, `rsp_id` and `rsp_result` stay stable, and `req_ready` stays 0 throughout; the response completes on the cycle `rsp_ready` rises.
4. Wrap-around: after a grant to requester 3, assert requesters 1 and 2. Required: requester 1 is granted first.
5. Reset mid-operation: assert `rst` in EXEC. Required: the next cycle shows all reset values and no `rsp_valid` for the discarded operation.
6. With `ALU_ARB_PRIO_EN` defined, hold requesters 0 and 3 valid. Required: requester 0 wins every IDLE cycle, and requester 3 is granted only after `req_valid[0]` drops.
